// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl
//   Round-robin front end for one shared serial pattern detector. Two
//   requesters offer WIDTH-bit words. A granted word is latched, the detector
//   is cleared for one cycle, and the word is shifted out MSB first on det_x.
//   The detector's Mealy match flag det_z is counted, and the owner id and
//   match count are reported in a one-cycle result pulse.
//
// Ports
//   clk, rst_n             clock; asynchronous active-low reset
//   req0_valid/data/ready  requester 0 offer/accept handshake
//   req1_valid/data/ready  requester 1 offer/accept handshake
//   det_x                  serial bit to the detector
//   det_rst_n              registered active-low detector clear
//   det_z                  detector match flag, same cycle as det_x
//   res_valid/id/count     one-cycle result pulse, owner id, match count
//   busy                   high whenever the controller is not idle
module pattern_scan_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req0_valid,
   input  logic [WIDTH-1:0]           req0_data,
   output logic                       req0_ready,
   input  logic                       req1_valid,
   input  logic [WIDTH-1:0]           req1_data,
   output logic                       req1_ready,
   output logic                       det_x,
   output logic                       det_rst_n,
   input  logic                       det_z,
   output logic                       res_valid,
   output logic                       res_id,
   output logic [$clog2(WIDTH+1)-1:0] res_count,
   output logic                       busy
);

   localparam int CW = $clog2(WIDTH+1);

   typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, REPORT} state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    bit_cnt;
   logic [CW-1:0]    match_cnt;
   logic             cur_id;
   logic             last_id;    // id granted most recently; tie goes to the other one

   logic             grant1;
   logic             take;
   logic             match_inc;
   logic [CW-1:0]    match_next;

   // Grant selection: a sole requester wins, a tie goes to the one not
   // granted last. last_id resets to 1 so req0 wins the first tie.
   always_comb begin
      grant1 = 1'b0;
      if (req0_valid && req1_valid)
         grant1 = ~last_id;
      else
         grant1 = req1_valid;
   end

   // Ready is gated by rst_n so both readys read low while reset is held.
   assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant1;
   assign req1_ready = rst_n && (state == IDLE) && grant1;
   assign take       = req0_ready || req1_ready;

   // Saturating guard: the count cannot pass WIDTH even if det_z misbehaves.
   assign match_inc  = det_z && (match_cnt != CW'(WIDTH));
   assign match_next = match_cnt + CW'(match_inc);

   assign det_x = (state == SHIFT) && shreg[WIDTH-1];
   assign busy  = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shreg     <= '0;
         bit_cnt   <= '0;
         match_cnt <= '0;
         cur_id    <= 1'b0;
         last_id   <= 1'b1;
         det_rst_n <= 1'b0;
         res_valid <= 1'b0;
         res_id    <= 1'b0;
         res_count <= '0;
      end else begin
         det_rst_n <= 1'b1;
         res_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (take) begin
                  shreg     <= grant1 ? req1_data : req0_data;
                  cur_id    <= grant1;
                  last_id   <= grant1;
                  match_cnt <= '0;
                  bit_cnt   <= '0;
                  det_rst_n <= 1'b0;   // low for the single CLEAR cycle
                  state     <= CLEAR;
               end
            end
            CLEAR: begin
               state <= SHIFT;
            end
            SHIFT: begin
               shreg     <= {shreg[WIDTH-2:0], 1'b0};
               match_cnt <= match_next;
               if (bit_cnt == CW'(WIDTH-1)) begin
                  // Final bit: the last det_z sample is folded straight in.
                  state     <= REPORT;
                  res_valid <= 1'b1;
                  res_id    <= cur_id;
                  res_count <= match_next;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            REPORT: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bits per scanned word (legal 2..16).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req0_valid  input  1  requester 0 offers a word.
REQ-005 SHALL have port req0_data  input  WIDTH  requester 0 word, scanned MSB first.
REQ-006 SHALL have port req0_ready  output  1  requester 0 word accepted this cycle.
REQ-007 SHALL have port req1_valid  input  1  requester 1 offers a word.
REQ-008 SHALL have port req1_data  input  WIDTH  requester 1 word, scanned MSB first.
REQ-009 SHALL have port req1_ready  output  1  requester 1 word accepted this cycle.
REQ-010 SHALL have port det_x  output  1  serial bit to the shared detector.
REQ-011 SHALL have port det_rst_n  output  1  registered active-low clear to the shared detector.
REQ-012 SHALL have port det_z  input  1  detector match flag (Mealy, same-cycle as det_x).
REQ-013 SHALL have port res_valid  output  1  one-cycle result pulse.
REQ-014 SHALL have port res_id  output  1  requester that owns the result.
REQ-015 SHALL have port res_count  output  $clog2(WIDTH+1)  matches counted in the word.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, SHIFT, REPORT.
REQ-018 IDLE: SHALL assert exactly one reqN_ready combinationally when any reqN_valid is high; transfer occurs on valid&&ready at a rising edge.
REQ-019 Arbitration SHALL be round-robin: sole requester always wins; with both valid, the requester not granted last wins; after reset, req0 wins the first tie.
REQ-020 On transfer SHALL latch data into a WIDTH-bit shift register, latch the id, clear the match count and bit counter, and go to CLEAR.
REQ-021 ready SHALL be low in CLEAR, SHIFT, REPORT; valids there are ignored and data need not be held.
REQ-022 CLEAR: SHALL drive det_rst_n low for exactly one cycle, det_x = 0, then go to SHIFT.
REQ-023 SHIFT: SHALL drive det_x = shift-register MSB for exactly WIDTH consecutive cycles, shifting left by one each cycle.
REQ-024 SHIFT: SHALL sample det_z each cycle and increment the count when high; count SHALL never exceed WIDTH.
REQ-025 After the WIDTH-th bit SHALL go to REPORT; REPORT SHALL hold res_valid = 1 for one cycle with res_id and res_count, then return to IDLE.
REQ-026 Latency: transfer at edge T; CLEAR cycle T..T+1; bits on det_x in cycles T+1..T+WIDTH; res_valid high in cycle T+WIDTH+1; next ready earliest cycle T+WIDTH+2.
REQ-027 res_id, res_count SHALL hold their last value outside REPORT; res_valid SHALL be 0 outside REPORT.
REQ-028 det_rst_n SHALL be high in IDLE, SHIFT, REPORT.
REQ-029 det_z outside SHIFT SHALL be ignored.
REQ-030 Round-robin pointer SHALL update only on a transfer.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, det_rst_n = 0, det_x = 0, res_valid = 0, res_id = 0, res_count = 0, busy = 0, both readys = 0 while rst_n is low, tie pointer to req0.
REQ-032 Reset mid-scan SHALL abandon the word with no result pulse; first cycle after release SHALL be IDLE with det_rst_n = 1.

Verification
REQ-033 WIDTH=8, req0 sends 8'b1010_1010, stub 1010 non-overlap Mealy detector -> det_x 1,0,1,0,1,0,1,0 in cycles T+1..T+8, res_valid at T+9, res_id 0, res_count 2.
REQ-034 Both valid from reset -> req0 granted first; both held valid -> grants alternate 0,1,0,1 with results in that order.
REQ-035 Only req1 valid twice in a row -> req1 granted both times; req0 arrives during SHIFT -> granted at next IDLE.
REQ-036 Word 8'h00 with det_z tied 1 -> res_count 8 (no overflow); det_z tied 0 -> res_count 0.
REQ-037 rst_n pulsed low during 4th SHIFT bit -> outputs at reset values immediately, no res_valid, next word scanned normally with det_rst_n low one cycle in CLEAR.
REQ-038 Check det_rst_n low exactly one cycle per word, and readys never high outside IDLE.
